// File: rtl/wb_rbcp_initiator_pkg.sv
// Shared types and constants for the Wishbone-to-RBCP initiator bridge.
package wb_rbcp_initiator_pkg;

  localparam int RBCP_ADDR_W = 32;
  localparam int RBCP_DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    RESP  = 3'd3,
    GAP   = 3'd4
  } state_t;

  typedef enum logic {
    RSP_OK      = 1'b0,
    RSP_TIMEOUT = 1'b1
  } rsp_kind_t;

  // States in which a responder ACK is unsolicited.
  function automatic logic is_stray_state(input state_t s);
    return (s == IDLE) || (s == RESP) || (s == GAP);
  endfunction

endpackage

// File: rtl/wb_rbcp_initiator_rbcp_timeout_timer.sv
// Saturating cycle counter with clear/enable; expire_o flags the last cycle
// before the terminal count is reached.
module rbcp_timeout_timer #(
  parameter int unsigned TERMINAL = 255
) (
  input  logic CLK,
  input  logic RST,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int unsigned W = $clog2(TERMINAL + 1);
  localparam logic [W-1:0] LAST = W'(TERMINAL - 1);
  localparam logic [W-1:0] TOP  = W'(TERMINAL);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != TOP)) begin
      cnt_d = cnt_q + W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = (cnt_q == LAST);

endmodule

// File: rtl/wb_rbcp_initiator.sv
// Wishbone slave to RBCP master bridge: issues single-byte RBCP write/read
// transactions and converts responder silence into a Wishbone error.
module wb_rbcp_initiator
  import wb_rbcp_initiator_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned IDLE_GAP       = 1
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   wb_cyc_i,
  input  logic                   wb_stb_i,
  input  logic                   wb_we_i,
  input  logic [RBCP_ADDR_W-1:0] wb_adr_i,
  input  logic [RBCP_DATA_W-1:0] wb_dat_i,
  output logic [RBCP_DATA_W-1:0] wb_dat_o,
  output logic                   wb_ack_o,
  output logic                   wb_err_o,
  output logic                   RBCP_ACT,
  output logic [RBCP_ADDR_W-1:0] RBCP_ADDR,
  output logic                   RBCP_WE,
  output logic [RBCP_DATA_W-1:0] RBCP_WD,
  output logic                   RBCP_RE,
  input  logic [RBCP_DATA_W-1:0] RBCP_RD,
  input  logic                   RBCP_ACK,
  output logic                   busy_o,
  output logic                   stray_ack_o
);

  state_t                 state_q;
  rsp_kind_t              rsp_q;
  logic                   abort_q;
  logic                   we_q;
  logic                   act_q;
  logic                   rbcp_we_q;
  logic                   rbcp_re_q;
  logic [RBCP_ADDR_W-1:0] addr_q;
  logic [RBCP_DATA_W-1:0] wd_q;
  logic [RBCP_DATA_W-1:0] rdata_q;
  logic                   ack_q;
  logic                   err_q;
  logic                   busy_q;
  logic                   stray_q;

  logic tmo_expire;
  logic gap_expire;

  rbcp_timeout_timer #(.TERMINAL(TIMEOUT_CYCLES)) u_tmo (
    .CLK      (CLK),
    .RST      (RST),
    .clr_i    (state_q == ISSUE),
    .en_i     (state_q == WAIT),
    .expire_o (tmo_expire)
  );

  rbcp_timeout_timer #(.TERMINAL(IDLE_GAP)) u_gap (
    .CLK      (CLK),
    .RST      (RST),
    .clr_i    (state_q == RESP),
    .en_i     (state_q == GAP),
    .expire_o (gap_expire)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      rsp_q     <= RSP_OK;
      abort_q   <= 1'b0;
      we_q      <= 1'b0;
      act_q     <= 1'b0;
      rbcp_we_q <= 1'b0;
      rbcp_re_q <= 1'b0;
      addr_q    <= '0;
      wd_q      <= '0;
      rdata_q   <= '0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      stray_q   <= 1'b0;
    end else begin
      rbcp_we_q <= 1'b0;
      rbcp_re_q <= 1'b0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      stray_q   <= RBCP_ACK & is_stray_state(state_q);
      case (state_q)
        IDLE: begin
          if (wb_cyc_i && wb_stb_i) begin
            addr_q    <= wb_adr_i;
            wd_q      <= wb_dat_i;
            we_q      <= wb_we_i;
            abort_q   <= 1'b0;
            act_q     <= 1'b1;
            busy_q    <= 1'b1;
            rbcp_we_q <= wb_we_i;
            rbcp_re_q <= ~wb_we_i;
            state_q   <= ISSUE;
          end
        end
        ISSUE, WAIT: begin
          // An RBCP transaction cannot be cancelled; a dropped cycle only
          // suppresses the Wishbone termination.
          if (!wb_cyc_i) begin
            abort_q <= 1'b1;
          end
          if (RBCP_ACK) begin
            if (!we_q) begin
              rdata_q <= RBCP_RD;
            end
            rsp_q   <= RSP_OK;
            act_q   <= 1'b0;
            state_q <= RESP;
          end else if ((state_q == WAIT) && tmo_expire) begin
            rsp_q   <= RSP_TIMEOUT;
            act_q   <= 1'b0;
            state_q <= RESP;
          end else begin
            state_q <= WAIT;
          end
        end
        RESP: begin
          if (wb_cyc_i && wb_stb_i && !abort_q) begin
            ack_q <= (rsp_q == RSP_OK);
            err_q <= (rsp_q == RSP_TIMEOUT);
          end
          state_q <= GAP;
        end
        GAP: begin
          if (gap_expire) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          act_q   <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign wb_dat_o    = rdata_q;
  assign wb_ack_o    = ack_q;
  assign wb_err_o    = err_q;
  assign RBCP_ACT    = act_q;
  assign RBCP_ADDR   = addr_q;
  assign RBCP_WE     = rbcp_we_q;
  assign RBCP_WD     = wd_q;
  assign RBCP_RE     = rbcp_re_q;
  assign busy_o      = busy_q;
  assign stray_ack_o = stray_q;

endmodule

// File: doc/wb_rbcp_initiator.md
Name: wb_rbcp_initiator

Overview:
- Wishbone-slave to RBCP-master bridge: the initiator end of the RBCP bus.
- Lets an on-chip Wishbone master (test sequencer, loopback BIST, soft CPU) issue single-byte RBCP write/read transactions into any RBCP responder, e.g. the register-file/arbitrator block.
- Drives ACT/ADDR/WE/RE/WD, waits for ACK, returns RD.
- Maps responder silence to a Wishbone error after a programmable timeout.

Parameters:
- TIMEOUT_CYCLES, 255: cycles to wait for RBCP_ACK after the WE/RE pulse before aborting; legal range 1..65535.
- IDLE_GAP, 1: minimum cycles RBCP_ACT stays low between transactions; legal range 1..15.

Ports:
- CLK  in  1  system clock
- RST  in  1  synchronous active-high reset
- wb_cyc_i  in  1  Wishbone cycle
- wb_stb_i  in  1  Wishbone strobe
- wb_we_i  in  1  1 = write, 0 = read
- wb_adr_i  in  32  target RBCP address
- wb_dat_i  in  8  write data
- wb_dat_o  out  8  read data
- wb_ack_o  out  1  normal termination, one-cycle pulse
- wb_err_o  out  1  timeout termination, one-cycle pulse
- RBCP_ACT  out  1  transaction active
- RBCP_ADDR  out  32  address
- RBCP_WE  out  1  write pulse
- RBCP_WD  out  8  write data
- RBCP_RE  out  1  read pulse
- RBCP_RD  in  8  read data, valid with RBCP_ACK
- RBCP_ACK  in  1  responder acknowledge
- busy_o  out  1  high in every state except IDLE
- stray_ack_o  out  1  one-cycle pulse when RBCP_ACK arrives outside ISSUE/WAIT

Behaviour:
- Reset values: all outputs 0; state IDLE; counters 0. Reset has priority at every state. If reset occurs mid-transaction, ACT drops on the next edge and no wb_ack_o or wb_err_o is emitted.
- Output timing: every output is registered. RBCP_ADDR and RBCP_WD hold their latched values from ISSUE through GAP.
- FSM:
  - IDLE: if wb_cyc_i & wb_stb_i at edge N, latch adr/dat/we and go to ISSUE.
  - ISSUE (cycle N+1): ACT=1. Exactly one of WE/RE=1 for this single cycle. Timeout counter cleared. Go to WAIT.
  - WAIT: ACT=1 and the counter increments each cycle.
    - RBCP_ACK sampled in ISSUE or WAIT: capture RBCP_RD into wb_dat_o (reads only; writes leave wb_dat_o unchanged), go to RESP ok.
    - Counter == TIMEOUT_CYCLES-1 with no ACK: go to RESP err.
    - If ACK and timeout occur in the same cycle, ACK wins.
  - RESP (one cycle): ACT=0. Pulse wb_ack_o (ok) or wb_err_o (err), only if wb_cyc_i & wb_stb_i are still high; otherwise emit no pulse. A timed-out read leaves wb_dat_o unchanged. Go to GAP.
  - GAP: ACT=0 for IDLE_GAP cycles, then IDLE. STB is ignored in RESP and GAP, so back-to-back requests see ACT low for IDLE_GAP+1 cycles minimum.
- Latency: ACK at edge K gives wb_ack_o at edge K+1. The minimum transaction is STB N, ACT N+1, ACK N+1, wb_ack_o N+2.
- Abort: if wb_cyc_i drops during ISSUE/WAIT, the RBCP transaction still completes (ACK or timeout), because RBCP cannot be cancelled. The WB response is suppressed. The next request is only accepted in IDLE.
- Stray ACK: RBCP_ACK in IDLE/RESP/GAP is ignored for data and pulses stray_ack_o the following cycle.
- Counter width: clog2(TIMEOUT_CYCLES+1). Saturates and never wraps.

Decomposition:
- Shared package:
  - state enum {IDLE, ISSUE, WAIT, RESP, GAP}
  - RBCP_ADDR_W=32, RBCP_DATA_W=8 constants
  - response-kind enum {RSP_OK, RSP_TIMEOUT}
- Sub-module: rbcp_timeout_timer (clear/enable/expire, parameterised terminal count). It is reused by the gap counter with terminal count IDLE_GAP.
- The FSM and datapath stay in the top module.

Test Plan:
- Write: WB write adr=0x0000_0010, dat=0xA5; responder ACKs 3 cycles after WE -> one-cycle WE with ADDR=0x10, WD=0xA5; wb_ack_o exactly 1 cycle after ACK; wb_err_o never asserts.
- Read: WB read adr=0x0001_0003; responder returns RD=0x5C with ACK in the same cycle as RE -> wb_dat_o=0x5C and wb_ack_o at STB+2; ACT high for exactly 1 cycle.
- Timeout: TIMEOUT_CYCLES=8, responder silent -> ACT high 9 cycles (ISSUE plus 8 WAIT); wb_err_o pulse; wb_dat_o keeps its prior value; busy_o returns to 0 after GAP.
- Abort and simultaneous events: wb_cyc_i dropped 2 cycles into WAIT, ACK arrives 5 cycles later -> ACT held until ACK, no wb_ack_o. In a separate run, ACK lands in the timeout cycle -> wb_ack_o, not wb_err_o.
- Back-to-back: two writes with STB held continuously, IDLE_GAP=3 -> ACT low for at least 4 cycles between transactions; both wb_ack_o pulses occur; ADDR/WD match each request.
- Stray ACK and reset: ACK pulsed in IDLE -> stray_ack_o pulse, no WB response. RST asserted during WAIT -> next cycle all outputs 0, state IDLE, a later ACK only raises stray_ack_o.
